// File: rtl/operand_bypass_unit_pkg.sv
// Shared encodings and tag-slot layout for the ID-stage operand bypass unit.
// No logic: types, defaults and one tag-match helper.
package operand_bypass_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    localparam int TAG_RD_W     = 8;
    localparam int LINK_REG_DEF = 31;
    localparam int SYS_RA0_DEF  = 2;
    localparam int SYS_RA1_DEF  = 4;

    // is_load only matters while the producer sits in EX, so it lives beside the EX tag.
    typedef struct packed {
        logic                valid;
        logic                wen;
        logic [TAG_RD_W-1:0] rd;
    } tag_t;

    function automatic logic tag_hit(input tag_t t, input logic [TAG_RD_W-1:0] src);
        return t.valid && t.wen && (t.rd == src) && (src != '0);
    endfunction

endpackage

// File: rtl/operand_bypass_unit_if.sv
// ID/EX operand bus between pipeline control (master) and the bypass unit (slave).
// Pure wiring; latency and backpressure are defined by the bypass unit.
interface operand_bypass_unit_if #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2
);
    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_src;
    logic [NUM_SRC*DATA_W-1:0] id_rf_data;
    logic                      id_wen;
    logic                      id_is_load;
    logic                      id_link;
    logic                      id_syscall;
    logic [REG_AW-1:0]         id_rd;
    logic [DATA_W-1:0]         ex_data;
    logic [DATA_W-1:0]         mem_data;
    logic [DATA_W-1:0]         wb_data;
    logic                      mem_wait;
    logic                      flush;
    logic [NUM_SRC*DATA_W-1:0] ex_opnd;
    logic [REG_AW-1:0]         ex_rd;
    logic                      ex_valid;
    logic                      stall;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic [31:0]               stall_cnt;

    modport master (
        output id_valid, id_src, id_rf_data, id_wen, id_is_load, id_link, id_syscall,
               id_rd, ex_data, mem_data, wb_data, mem_wait, flush,
        input  ex_opnd, ex_rd, ex_valid, stall, fwd_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_src, id_rf_data, id_wen, id_is_load, id_link, id_syscall,
               id_rd, ex_data, mem_data, wb_data, mem_wait, flush,
        output ex_opnd, ex_rd, ex_valid, stall, fwd_sel, stall_cnt
    );
endinterface

// File: rtl/operand_bypass_unit_fwd_select.sv
// Per-source priority compare (EX > MEM > WB > RF) and operand mux.
// Combinational, zero latency; flags a load-use hit against the EX producer.
module operand_bypass_unit_fwd_select
    import operand_bypass_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [DATA_W-1:0] rf_dat_i,
    input  logic [DATA_W-1:0] ex_dat_i,
    input  logic [DATA_W-1:0] mem_dat_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  tag_t              ex_tag_i,
    input  tag_t              mem_tag_i,
    input  tag_t              wb_tag_i,
    input  logic              ex_is_load_i,
    output logic [1:0]        sel_o,
    output logic [DATA_W-1:0] opnd_o,
    output logic              ld_hit_o
);
    logic [TAG_RD_W-1:0] src_ext;
    logic                hit_ex;
    logic                hit_mem;
    logic                hit_wb;

    assign src_ext = TAG_RD_W'(src_i);
    assign hit_ex  = tag_hit(ex_tag_i, src_ext);
    assign hit_mem = tag_hit(mem_tag_i, src_ext);
    assign hit_wb  = tag_hit(wb_tag_i, src_ext);

    always_comb begin
        sel_o  = FWD_RF;
        opnd_o = rf_dat_i;
        if (hit_ex) begin
            sel_o  = FWD_EX;
            opnd_o = ex_dat_i;
        end else if (hit_mem) begin
            sel_o  = FWD_MEM;
            opnd_o = mem_dat_i;
        end else if (hit_wb) begin
            sel_o  = FWD_WB;
            opnd_o = wb_dat_i;
        end
    end

    assign ld_hit_o = hit_ex && ex_is_load_i;

endmodule

// File: rtl/operand_bypass_unit.sv
// ID-stage operand bypass, load-use hazard detection and ID/EX operand latch.
// Operands registered one edge after issue; mem_wait freezes everything, load-use stalls ID one cycle.
module operand_bypass_unit
    import operand_bypass_unit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LINK_REG = LINK_REG_DEF,
    parameter int SYS_RA0  = SYS_RA0_DEF,
    parameter int SYS_RA1  = SYS_RA1_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    operand_bypass_unit_if.slave  bus
);
    tag_t                      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic                      ex_ld_q, ex_ld_d;
    logic [NUM_SRC*DATA_W-1:0] opnd_q, opnd_d;
    logic [31:0]               cnt_q, cnt_d;

    logic [NUM_SRC*REG_AW-1:0] eff_src;
    logic [REG_AW-1:0]         eff_rd;
    logic [NUM_SRC*DATA_W-1:0] opnd_sel;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic [NUM_SRC-1:0]        ld_hit;
    logic                      lu_stall;
    logic                      kill;

    always_comb begin
        eff_src = bus.id_src;
        if (bus.id_syscall) begin
            eff_src[0 +: REG_AW]      = REG_AW'(SYS_RA0);
            eff_src[REG_AW +: REG_AW] = REG_AW'(SYS_RA1);
        end
    end

    assign eff_rd = bus.id_link ? REG_AW'(LINK_REG) : bus.id_rd;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        operand_bypass_unit_fwd_select #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW)
        ) u_fwd_select (
            .src_i        (eff_src[k*REG_AW +: REG_AW]),
            .rf_dat_i     (bus.id_rf_data[k*DATA_W +: DATA_W]),
            .ex_dat_i     (bus.ex_data),
            .mem_dat_i    (bus.mem_data),
            .wb_dat_i     (bus.wb_data),
            .ex_tag_i     (ex_q),
            .mem_tag_i    (mem_q),
            .wb_tag_i     (wb_q),
            .ex_is_load_i (ex_ld_q),
            .sel_o        (fwd_sel[k*2 +: 2]),
            .opnd_o       (opnd_sel[k*DATA_W +: DATA_W]),
            .ld_hit_o     (ld_hit[k])
        );
    end

    assign lu_stall = bus.id_valid && (|ld_hit);
    // Flush and load-use both turn the issue slot into a bubble; stall still reports the hazard.
    assign kill     = lu_stall || bus.flush || !bus.id_valid;

    always_comb begin
        ex_d    = ex_q;
        ex_ld_d = ex_ld_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        if (!bus.mem_wait) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (kill) begin
                ex_d.valid = 1'b0;
                ex_d.wen   = 1'b0;
                ex_ld_d    = 1'b0;
            end else begin
                ex_d    = '{valid: 1'b1, wen: bus.id_wen, rd: TAG_RD_W'(eff_rd)};
                ex_ld_d = bus.id_is_load;
                opnd_d  = opnd_sel;
            end
            if (lu_stall && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            ex_ld_q <= 1'b0;
            mem_q   <= '0;
            wb_q    <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            ex_ld_q <= ex_ld_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ex_opnd   = opnd_q;
    assign bus.ex_rd     = ex_q.rd[REG_AW-1:0];
    assign bus.ex_valid  = ex_q.valid;
    assign bus.stall     = lu_stall || bus.mem_wait;
    assign bus.fwd_sel   = fwd_sel;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Directed bench for operand_bypass_unit: in-flight instruction model checked every negedge,
// plus hand-computed literal expectations at the interesting points of each scenario.
module tb_operand_bypass_unit;
    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    operand_bypass_unit_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) bus ();

    operand_bypass_unit #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .NUM_SRC(NUM_SRC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: stage 0 = EX, 1 = MEM, 2 = WB; each entry is one in-flight instruction.
    bit          m_v [3];
    bit          m_w [3];
    int          m_rd[3];
    bit          m_ld[3];
    logic [31:0] m_opnd[NUM_SRC];
    longint      m_cnt;

    int          e_sel[NUM_SRC];
    logic [31:0] e_val[NUM_SRC];
    bit          e_lu;
    bit          e_stall;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int eff_src(input int k);
        if (bus.id_syscall && k == 0) return 2;
        if (bus.id_syscall && k == 1) return 4;
        return int'(bus.id_src[k*REG_AW +: REG_AW]);
    endfunction

    function automatic logic [31:0] stage_data(input int st);
        if (st == 0) return bus.ex_data;
        if (st == 1) return bus.mem_data;
        return bus.wb_data;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 3; s++) begin
            m_v[s] = 0; m_w[s] = 0; m_rd[s] = 0; m_ld[s] = 0;
        end
        for (int k = 0; k < NUM_SRC; k++) m_opnd[k] = '0;
        m_cnt = 0;
    endfunction

    // Youngest matching producer wins: scan oldest to youngest and let later hits overwrite.
    function automatic void calc();
        bit lu;
        lu = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int s;
            s        = eff_src(k);
            e_sel[k] = 0;
            e_val[k] = bus.id_rf_data[k*DATA_W +: DATA_W];
            if (s != 0) begin
                for (int st = 2; st >= 0; st--) begin
                    if (m_v[st] && m_w[st] && m_rd[st] == s) begin
                        e_sel[k] = st + 1;
                        e_val[k] = stage_data(st);
                    end
                end
                if (m_v[0] && m_w[0] && m_rd[0] == s && m_ld[0]) lu = 1;
            end
        end
        e_lu    = lu && bus.id_valid;
        e_stall = e_lu || bus.mem_wait;
    endfunction

    function automatic void model_step();
        calc();
        if (!bus.mem_wait) begin
            if (e_lu && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            for (int s = 2; s > 0; s--) begin
                m_v[s] = m_v[s-1]; m_w[s] = m_w[s-1]; m_rd[s] = m_rd[s-1]; m_ld[s] = m_ld[s-1];
            end
            if (e_lu || bus.flush || !bus.id_valid) begin
                m_v[0] = 0; m_w[0] = 0; m_ld[0] = 0;
            end else begin
                m_v[0]  = 1;
                m_w[0]  = bus.id_wen;
                m_rd[0] = bus.id_link ? 31 : int'(bus.id_rd);
                m_ld[0] = bus.id_is_load;
                for (int k = 0; k < NUM_SRC; k++) m_opnd[k] = e_val[k];
            end
        end
    endfunction

    always @(negedge clk) begin
        calc();
        chk("cmp_stall", 64'(bus.stall), 64'(e_stall));
        for (int k = 0; k < NUM_SRC; k++) begin
            chk($sformatf("cmp_fwd_sel%0d", k), 64'(bus.fwd_sel[k*2 +: 2]), 64'(e_sel[k]));
            chk($sformatf("cmp_ex_opnd%0d", k), 64'(bus.ex_opnd[k*DATA_W +: DATA_W]), 64'(m_opnd[k]));
        end
        chk("cmp_ex_valid", 64'(bus.ex_valid), 64'(m_v[0]));
        if (m_v[0]) chk("cmp_ex_rd", 64'(bus.ex_rd), 64'(m_rd[0]));
        chk("cmp_stall_cnt", 64'(bus.stall_cnt), 64'(m_cnt));
    end

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    function automatic logic [31:0] rfval(input int r);
        return (r == 0) ? 32'h0 : 32'h100 + 32'(r);
    endfunction

    task automatic set_id(input bit v, input int s0, input int s1, input int rd, input bit wen,
                          input bit ld, input bit link, input bit sys);
        bus.id_valid   = v;
        bus.id_src     = {REG_AW'(s1), REG_AW'(s0)};
        bus.id_rf_data = {rfval(s1), rfval(s0)};
        bus.id_rd      = REG_AW'(rd);
        bus.id_wen     = wen;
        bus.id_is_load = ld;
        bus.id_link    = link;
        bus.id_syscall = sys;
    endtask

    initial begin
        rst_n = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        bus.ex_data  = 32'hE0E0;
        bus.mem_data = 32'hD0D0;
        bus.wb_data  = 32'hB0B0;
        bus.mem_wait = 1'b0;
        bus.flush    = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        cyc();
        chk("rst_ex_valid", 64'(bus.ex_valid), 0);
        chk("rst_ex_rd", 64'(bus.ex_rd), 0);
        chk("rst_ex_opnd", 64'(bus.ex_opnd), 0);
        chk("rst_stall", 64'(bus.stall), 0);
        chk("rst_stall_cnt", 64'(bus.stall_cnt), 0);
        chk("rst_fwd_sel", 64'(bus.fwd_sel), 0);
        cyc();
        rst_n = 1'b1;

        // add $3 <- $1,$2 then consumer of $3 forwards from EX
        set_id(1, 1, 2, 3, 1, 0, 0, 0); cyc();
        set_id(1, 3, 0, 6, 1, 0, 0, 0); bus.ex_data = 32'h11; #1;
        chk("add_fwd_sel0", 64'(bus.fwd_sel[1:0]), 1);
        chk("add_stall", 64'(bus.stall), 0);
        cyc();
        chk("add_ex_opnd0", 64'(bus.ex_opnd[31:0]), 64'h11);

        // lw $5 then use: one bubble, then MEM forward
        set_id(1, 1, 0, 5, 1, 1, 0, 0); cyc();
        set_id(1, 5, 0, 7, 1, 0, 0, 0); #1;
        chk("lu_stall", 64'(bus.stall), 1);
        chk("lu_fwd_sel0_ex", 64'(bus.fwd_sel[1:0]), 1);
        cyc();
        chk("lu_bubble", 64'(bus.ex_valid), 0);
        chk("lu_stall_cnt", 64'(bus.stall_cnt), 1);
        bus.mem_data = 32'hDEAD; #1;
        chk("lu_fwd_sel0_mem", 64'(bus.fwd_sel[1:0]), 2);
        chk("lu_stall_clear", 64'(bus.stall), 0);
        cyc();
        chk("lu_ex_opnd0", 64'(bus.ex_opnd[31:0]), 64'hDEAD);
        chk("lu_ex_valid", 64'(bus.ex_valid), 1);

        // write to $0 never forwards
        set_id(1, 1, 2, 0, 1, 0, 0, 0); cyc();
        set_id(1, 0, 0, 8, 1, 0, 0, 0); bus.ex_data = 32'h55; #1;
        chk("r0_fwd_sel", 64'(bus.fwd_sel), 0);
        cyc();
        chk("r0_ex_opnd", 64'(bus.ex_opnd), 0);

        // syscall: $2 in MEM, $4 in WB
        set_id(1, 1, 1, 4, 1, 0, 0, 0); cyc();
        set_id(1, 1, 1, 2, 1, 0, 0, 0); cyc();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); cyc();
        set_id(1, 7, 8, 9, 0, 0, 0, 1);
        bus.ex_data = 32'h99; bus.mem_data = 32'hA; bus.wb_data = 32'hB; #1;
        chk("sys_fwd_sel", 64'(bus.fwd_sel), 64'hE);
        cyc();
        chk("sys_ex_opnd", 64'(bus.ex_opnd), 64'h0000000B_0000000A);

        // same register in EX and MEM: EX wins
        set_id(1, 1, 1, 9, 1, 0, 0, 0); cyc();
        set_id(1, 1, 1, 9, 1, 0, 0, 0); cyc();
        set_id(1, 9, 0, 12, 1, 0, 0, 0); bus.ex_data = 32'h77; bus.mem_data = 32'h88; #1;
        chk("exmem_fwd_sel0", 64'(bus.fwd_sel[1:0]), 1);
        cyc();
        chk("exmem_ex_opnd0", 64'(bus.ex_opnd[31:0]), 64'h77);

        // jal forces $31
        set_id(1, 0, 0, 0, 1, 0, 1, 0); cyc();
        chk("jal_ex_rd", 64'(bus.ex_rd), 31);
        set_id(1, 31, 0, 13, 1, 0, 0, 0); #1;
        chk("jal_fwd_sel0", 64'(bus.fwd_sel[1:0]), 1);
        cyc();

        // flush together with load-use: bubble, stall still counted
        set_id(1, 1, 0, 10, 1, 1, 0, 0); cyc();
        set_id(1, 10, 0, 14, 1, 0, 0, 0); bus.flush = 1'b1; #1;
        chk("fl_stall", 64'(bus.stall), 1);
        cyc();
        bus.flush = 1'b0;
        chk("fl_bubble", 64'(bus.ex_valid), 0);
        chk("fl_stall_cnt", 64'(bus.stall_cnt), 2);

        // mem_wait during load-use freezes, then reset mid-freeze
        set_id(1, 1, 0, 11, 1, 1, 0, 0); cyc();
        set_id(1, 11, 0, 15, 1, 0, 0, 0); bus.mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("mw_ex_rd", 64'(bus.ex_rd), 11);
            chk("mw_ex_valid", 64'(bus.ex_valid), 1);
            chk("mw_stall_cnt", 64'(bus.stall_cnt), 2);
            chk("mw_stall", 64'(bus.stall), 1);
        end
        rst_n = 1'b0;
        model_reset(); #1;
        chk("mrst_ex_valid", 64'(bus.ex_valid), 0);
        chk("mrst_ex_rd", 64'(bus.ex_rd), 0);
        chk("mrst_ex_opnd", 64'(bus.ex_opnd), 0);
        chk("mrst_stall_cnt", 64'(bus.stall_cnt), 0);
        chk("mrst_fwd_sel", 64'(bus.fwd_sel), 0);
        cyc();
        rst_n = 1'b1;
        bus.mem_wait = 1'b0; #1;
        chk("post_rst_stall", 64'(bus.stall), 0);
        chk("post_rst_fwd_sel", 64'(bus.fwd_sel), 0);
        cyc();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_bypass_unit.md
# operand_bypass_unit

Parametrised ID-stage operand bypass, hazard and ID/EX operand-latch block for the 5-stage pipelined CPU. It tracks in-flight destinations in its own EX/MEM/WB tag pipeline and selects each source operand from EX, MEM, WB or register-file data. It latches the selected operands into registered ID/EX outputs and generates load-use stalls, pipeline freeze and flush bubbles. It supersedes the purely combinational select logic with syscall/jal register overrides kept as modes.

## Interface
- DATA_W, 32, datapath width
- REG_AW, 5, register-number width
- NUM_SRC, 2, source operands per instruction (≥2; syscall override uses sources 0 and 1)
- LINK_REG, 31, destination forced by link instructions
- SYS_RA0 / SYS_RA1, 2 / 4, sources forced by syscall
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  instruction present in ID
- id_src  in  NUM_SRC*REG_AW  source register numbers, slot k at [k*REG_AW +: REG_AW]
- id_rf_data  in  NUM_SRC*DATA_W  register-file read data per slot
- id_wen / id_is_load / id_link / id_syscall  in  1 each  ID-instruction attributes
- id_rd  in  REG_AW  destination before link override
- ex_data, mem_data, wb_data  in  DATA_W each  result currently produced in EX / MEM / WB (mem_data includes load data)
- mem_wait  in  1  memory not ready; freeze whole pipeline
- flush  in  1  kill instruction in ID (taken branch/jump)
- ex_opnd  out  NUM_SRC*DATA_W  registered operands for EX
- ex_rd  out  REG_AW  registered effective destination of EX slot
- ex_valid  out  1  EX slot holds a real instruction
- stall  out  1  hold PC and IF/ID (combinational)
- fwd_sel  out  NUM_SRC*2  per-slot source: 0 RF, 1 EX, 2 MEM, 3 WB (combinational)
- stall_cnt  out  32  load-use stall cycles since reset

## Operation
- Effective sources: id_syscall ? {SYS_RA0, SYS_RA1, rest unchanged} : id_src. Effective destination: id_link ? LINK_REG : id_rd.
- Tag pipeline: three slots EX, MEM, WB, each {valid, wen, rd, is_load}. Advance EX→MEM→WB each cycle unless mem_wait.
- Match(slot,k): slot.valid && slot.wen && slot.rd == src_k && src_k != 0.
- Priority per slot k: EX > MEM > WB > RF; operand = corresponding data input. Register 0 always RF (data 0 from RF).
- Load-use: id_valid && any k with Match(EX,k) && EX.is_load → stall=1; fwd_sel for that slot still reports 1.
- Issue condition: !mem_wait. On issue: if stall or flush or !id_valid, EX slot ← bubble (valid=0, wen=0), ex_opnd holds; else EX slot ← ID attributes and ex_opnd ← selected operands.
- mem_wait: all slots, ex_opnd, ex_rd, ex_valid hold; stall forced 1; stall_cnt does not count.
- flush and load-use stall together: flush wins for bubble; stall still asserted.
- stall_cnt increments on every cycle with load-use stall and !mem_wait; saturates at 0xFFFF_FFFF.

## Timing
- Reset (async, rst_n=0): all slots invalid, ex_opnd=0, ex_rd=0, ex_valid=0, stall_cnt=0; stall/fwd_sel follow inputs (all invalid → stall=0, fwd_sel=0).
- Reset mid-stall: in-flight tags discarded; first cycle after release has no hazards.
- Issue latency: ID operands appear on ex_opnd one clk edge after issue.
- Load-use costs exactly one bubble: load moves to MEM, dependent instruction then forwards from MEM (fwd_sel=2).
- Same register written by EX and MEM: EX value selected.

## Structure
- Shared package: fwd_sel encodings (FWD_RF/EX/MEM/WB), tag-slot struct/field widths, SYS_RA0/SYS_RA1/LINK_REG defaults.
- One sub-module: fwd_select (per-slot priority compare and mux), instantiated NUM_SRC times via generate.

## Test plan
- add $3 then add using $3 next cycle, ex_data=0x11 → fwd_sel slot0=1, ex_opnd=0x11, stall=0.
- lw $5 then use $5 → one cycle stall=1, EX bubble, next cycle fwd_sel=2 with mem_data=0xDEAD, stall_cnt=1.
- Write to $0 in EX, consumer reads $0 with ex_data=0x55 → fwd_sel=0, ex_opnd=RF value 0.
- syscall with id_src={7,8}, $2 in MEM (mem_data=0xA), $4 in WB (wb_data=0xB) → ex_opnd={0xA,0xB}.
- jal (id_link, id_rd=0) then consumer of $31 → ex_rd=31, then fwd_sel=1.
- mem_wait held 3 cycles during load-use → all outputs frozen, stall_cnt unchanged; rst_n pulled low mid-freeze → all outputs 0.
